// File: rtl/jk_counter_n_pkg.sv
// rtl/jk_counter_n_pkg.sv - mode encoding and clamp/wrap next-state function shared by counter-style blocks
package jk_counter_n_pkg;

  localparam int MAX_WIDTH = 16;
  localparam int CALC_W    = MAX_WIDTH + 1;

  typedef logic [CALC_W-1:0] calc_t;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  // One extra bit of headroom so q+1 at the top of a full-range count never wraps silently.
  function automatic calc_t next_count(input calc_t q, input mode_e mode,
                                       input calc_t d, input calc_t modulo);
    calc_t last;
    last = modulo - calc_t'(1);
    case (mode)
      MODE_UP:   next_count = (q == last) ? '0 : q + calc_t'(1);
      MODE_DOWN: next_count = (q == '0) ? last : q - calc_t'(1);
      MODE_LOAD: next_count = (d < modulo) ? d : last;
      default:   next_count = q;
    endcase
  endfunction

endpackage

// File: rtl/jk_counter_n_jk_cell.sv
// rtl/jk_counter_n_jk_cell.sv - one-bit synchronous JK flip-flop, clr over pr over J/K
module jk_cell (
  input  logic clk,
  input  logic clr,
  input  logic pr,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qn
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (pr) begin
      q_d = 1'b1;
    end else begin
      case ({j, k})
        2'b01:   q_d = 1'b0;
        2'b10:   q_d = 1'b1;
        2'b11:   q_d = ~q_q;
        default: q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) q_q <= 1'b0;
    else     q_q <= q_d;
  end

  assign q  = q_q;
  assign qn = ~q_q;

endmodule

// File: rtl/jk_counter_n.sv
// rtl/jk_counter_n.sv - modulo-N up/down/load counter built from a row of JK cells
import jk_counter_n_pkg::*;

module jk_counter_n #(
  parameter int WIDTH  = 4,
  parameter int MODULO = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             pr,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             tc
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("jk_counter_n: WIDTH must be 1..16");
  end
  if (MODULO < 2 || MODULO > (1 << WIDTH)) begin : g_bad_modulo
    $error("jk_counter_n: MODULO must be 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] Q_LAST = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] cell_clr;
  logic [WIDTH-1:0] cell_pr;

  always_comb begin
    n = q;
    if (en) begin
      n = WIDTH'(next_count(calc_t'(q), mode_e'(mode), calc_t'(d), calc_t'(MODULO)));
    end
    j = n & ~q;
    k = ~n & q;
  end

  // Preset loads MODULO-1: its one-bits use the cell preset, its zero-bits the cell clear.
  always_comb begin
    cell_pr  = {WIDTH{pr}} & Q_LAST;
    cell_clr = {WIDTH{clr}} | ({WIDTH{pr}} & ~Q_LAST);
  end

  always_comb begin
    tc = 1'b0;
    if (en && !clr && !pr) begin
      tc = ((mode_e'(mode) == MODE_UP)   && (q == Q_LAST)) ||
           ((mode_e'(mode) == MODE_DOWN) && (q == '0));
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .clr (cell_clr[i]),
      .pr  (cell_pr[i]),
      .j   (j[i]),
      .k   (k[i]),
      .q   (q[i]),
      .qn  (qn[i])
    );
  end

endmodule

// File: tb/tb_jk_counter_n.sv
// tb/tb_jk_counter_n.sv - scoreboard bench for jk_counter_n (mod 10 and full-range mod 8) and jk_cell
module tb_jk_counter_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr, pr, en;
  logic [1:0] mode;
  logic [3:0] d;
  logic [3:0] q_a, qn_a;
  logic       tc_a;
  logic [2:0] q_b, qn_b;
  logic       tc_b;
  logic       c_clr, c_pr, c_j, c_k, c_q, c_qn;

  int n_checks = 0;
  int n_fail   = 0;
  int mq_a = 0, mq_b = 0, mq_c = 0;
  int exp_q_a[$], exp_t_a[$], exp_q_b[$], exp_t_b[$], exp_c[$];

  jk_counter_n #(.WIDTH(4), .MODULO(10)) u_dut_a (
    .clk(clk), .clr(clr), .pr(pr), .en(en), .mode(mode), .d(d),
    .q(q_a), .qn(qn_a), .tc(tc_a)
  );

  jk_counter_n #(.WIDTH(3), .MODULO(8)) u_dut_b (
    .clk(clk), .clr(clr), .pr(pr), .en(en), .mode(mode), .d(d[2:0]),
    .q(q_b), .qn(qn_b), .tc(tc_b)
  );

  jk_cell u_cell (
    .clk(clk), .clr(c_clr), .pr(c_pr), .j(c_j), .k(c_k), .q(c_q), .qn(c_qn)
  );

  function automatic int ref_next(int q, bit c, bit p, bit e, int m, int dv, int md);
    if (c) return 0;
    if (p) return md - 1;
    if (!e) return q;
    case (m)
      1:       return (q + 1) % md;
      2:       return (q + md - 1) % md;
      3:       return (dv < md) ? dv : md - 1;
      default: return q;
    endcase
  endfunction

  function automatic int ref_tc(int q, bit c, bit p, bit e, int m, int md);
    return (e && !c && !p && ((m == 1 && q == md - 1) || (m == 2 && q == 0))) ? 1 : 0;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic step(bit c, bit p, bit e, int m, int dv);
    @(negedge clk);
    clr = c; pr = p; en = e; mode = 2'(m); d = 4'(dv);
    exp_t_a.push_back(ref_tc(mq_a, c, p, e, m, 10));
    exp_t_b.push_back(ref_tc(mq_b, c, p, e, m, 8));
    mq_a = ref_next(mq_a, c, p, e, m, dv, 10);
    mq_b = ref_next(mq_b, c, p, e, m, dv % 8, 8);
    exp_q_a.push_back(mq_a);
    exp_q_b.push_back(mq_b);
  endtask

  task automatic cell_step(bit c, bit p, bit jj, bit kk);
    @(negedge clk);
    c_clr = c; c_pr = p; c_j = jj; c_k = kk;
    if (c)             mq_c = 0;
    else if (p)        mq_c = 1;
    else if (jj && kk) mq_c = 1 - mq_c;
    else if (jj)       mq_c = 1;
    else if (kk)       mq_c = 0;
    exp_c.push_back(mq_c);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (exp_t_a.size() > 0) check("tc_a", {31'b0, tc_a}, exp_t_a.pop_front());
      if (exp_t_b.size() > 0) check("tc_b", {31'b0, tc_b}, exp_t_b.pop_front());
    end
  end

  initial begin
    int e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q_a.size() > 0) begin
        e = exp_q_a.pop_front();
        check("q_a", {28'b0, q_a}, e);
        check("qn_a", {28'b0, qn_a}, ~e & 15);
      end
      if (exp_q_b.size() > 0) begin
        e = exp_q_b.pop_front();
        check("q_b", {29'b0, q_b}, e);
        check("qn_b", {29'b0, qn_b}, ~e & 7);
      end
      if (exp_c.size() > 0) begin
        e = exp_c.pop_front();
        check("cell_q", {31'b0, c_q}, e);
        check("cell_qn", {31'b0, c_qn}, 1 - e);
      end
    end
  end

  initial begin
    clr = 1'b0; pr = 1'b0; en = 1'b0; mode = 2'b00; d = 4'd0;
    c_clr = 1'b0; c_pr = 1'b0; c_j = 1'b0; c_k = 1'b0;
    repeat (2) @(posedge clk);

    step(1, 0, 0, 0, 0);
    repeat (12) step(0, 0, 1, 1, 0);
    // B sits at 4 here: mid-count clear, then resume
    step(1, 0, 1, 1, 0);
    repeat (2) step(0, 0, 1, 1, 0);
    step(0, 0, 1, 3, 2);
    repeat (4) step(0, 0, 1, 2, 0);
    step(0, 0, 1, 3, 13);
    step(0, 0, 1, 3, 5);
    step(0, 0, 0, 3, 7);
    step(1, 1, 1, 1, 0);
    step(0, 1, 1, 1, 0);
    step(0, 0, 1, 2, 0);
    step(0, 0, 1, 0, 3);
    repeat (400) step($urandom_range(0, 31) == 0, $urandom_range(0, 31) == 0,
                      $urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 15));

    cell_step(1, 0, 0, 0);
    cell_step(0, 0, 0, 0);
    cell_step(0, 0, 1, 0);
    cell_step(0, 0, 0, 1);
    cell_step(0, 0, 1, 1);
    cell_step(0, 0, 1, 1);
    cell_step(0, 1, 0, 1);
    cell_step(1, 1, 1, 0);

    repeat (3) @(posedge clk);
    #2;
    check("queues_drained",
          exp_q_a.size() + exp_t_a.size() + exp_q_b.size() + exp_t_b.size() + exp_c.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
